// File: rtl/icache_nway.sv
// N-way set-associative read-only instruction cache with round-robin replacement,
// full invalidate (fence.i style) and a refill filter that drops stale memory responses.
module icache_nway #(
    parameter int unsigned WAYS      = 2,
    parameter int unsigned SET_BITS  = 6,
    parameter int unsigned LINE_BITS = 128
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [31:0]          i_paddr,
    input  logic                 i_req,
    output logic [LINE_BITS-1:0] o_rdata_line,
    output logic                 o_valid_out,
    output logic                 o_stall_cpu,
    input  logic                 i_flush_req,
    output logic                 o_flush_busy,
    output logic                 o_mem_req,
    output logic                 o_mem_we,
    output logic [31:0]          o_mem_addr,
    input  logic [LINE_BITS-1:0] i_mem_rdata,
    input  logic                 i_mem_ready,
    input  logic [31:0]          i_mem_resp_addr
);

    localparam int unsigned SETS     = 1 << SET_BITS;
    localparam int unsigned OFF_BITS = $clog2(LINE_BITS / 8);
    localparam int unsigned TAG_BITS = 32 - SET_BITS - OFF_BITS;
    localparam int unsigned WAY_W    = (WAYS > 1) ? $clog2(WAYS) : 1;

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StRefill = 2'd1;
    localparam logic [1:0] StFlush  = 2'd2;

    logic [1:0]                      r_state;
    logic                            r_flush_pend;
    logic [SET_BITS-1:0]             r_flush_cnt;
    logic [31:0]                     r_line_addr;
    logic [WAY_W-1:0]                r_way;
    logic                            r_valid_out;
    logic [SETS-1:0][WAYS-1:0]       r_valid;
    logic [SETS-1:0][WAY_W-1:0]      r_ptr;
    logic [TAG_BITS-1:0]             r_tag_arr  [SETS][WAYS];
    logic [LINE_BITS-1:0]            r_data_arr [SETS][WAYS];

    logic [SET_BITS-1:0]  w_idx;
    logic [TAG_BITS-1:0]  w_tag;
    logic [WAYS-1:0]      w_way_hit;
    logic [LINE_BITS-1:0] w_rdata;
    logic [WAY_W-1:0]     w_victim;
    logic                 w_found;
    logic                 w_hit;
    logic                 w_resp_match;
    logic [SET_BITS-1:0]  w_fill_idx;
    logic [WAY_W-1:0]     w_fill_ptr;
    logic [WAY_W-1:0]     w_fill_ptr_nxt;
    logic                 w_unused;

    assign w_idx      = i_paddr[OFF_BITS+SET_BITS-1:OFF_BITS];
    assign w_tag      = i_paddr[31:32-TAG_BITS];
    assign w_unused   = ^i_paddr[OFF_BITS-1:0];
    assign w_fill_idx = r_line_addr[OFF_BITS+SET_BITS-1:OFF_BITS];

    always_comb begin
        w_way_hit = '0;
        w_rdata   = '0;
        w_victim  = r_ptr[w_idx];
        w_found   = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            w_way_hit[w] = r_valid[w_idx][w] && (r_tag_arr[w_idx][w] == w_tag);
            if (w_way_hit[w]) begin
                w_rdata = r_data_arr[w_idx][w];
            end
            // Invalid ways are filled lowest-first before the pointer is consulted.
            if (!r_valid[w_idx][w] && !w_found) begin
                w_victim = WAY_W'(w);
                w_found  = 1'b1;
            end
        end
    end

    assign w_hit          = i_req && (r_state == StIdle) && !r_flush_pend && (|w_way_hit);
    assign w_resp_match   = i_mem_ready && (i_mem_resp_addr == r_line_addr);
    assign w_fill_ptr     = r_ptr[w_fill_idx];
    assign w_fill_ptr_nxt = (w_fill_ptr == WAY_W'(WAYS - 1)) ? '0 : w_fill_ptr + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= StIdle;
            r_flush_pend <= 1'b0;
            r_flush_cnt  <= '0;
            r_line_addr  <= '0;
            r_way        <= '0;
            r_valid_out  <= 1'b0;
            r_valid      <= '0;
            r_ptr        <= '0;
        end else begin
            r_valid_out <= w_hit;
            case (r_state)
                StIdle: begin
                    if (r_flush_pend || i_flush_req) begin
                        r_state      <= StFlush;
                        r_flush_cnt  <= '0;
                        r_flush_pend <= 1'b0;
                    end else if (i_req && !w_hit) begin
                        r_line_addr <= {i_paddr[31:OFF_BITS], {OFF_BITS{1'b0}}};
                        r_way       <= w_victim;
                        r_state     <= StRefill;
                    end
                end
                StRefill: begin
                    if (i_flush_req) begin
                        r_flush_pend <= 1'b1;
                    end
                    // Responses for any other line are stale and dropped.
                    if (w_resp_match) begin
                        r_valid[w_fill_idx][r_way] <= 1'b1;
                        if (r_way == w_fill_ptr) begin
                            r_ptr[w_fill_idx] <= w_fill_ptr_nxt;
                        end
                        r_state <= StIdle;
                    end
                end
                StFlush: begin
                    r_valid[r_flush_cnt] <= '0;
                    r_ptr[r_flush_cnt]   <= '0;
                    r_flush_cnt          <= r_flush_cnt + 1'b1;
                    if (r_flush_cnt == {SET_BITS{1'b1}}) begin
                        r_state <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if ((r_state == StRefill) && w_resp_match) begin
            r_tag_arr[w_fill_idx][r_way]  <= r_line_addr[31:32-TAG_BITS];
            r_data_arr[w_fill_idx][r_way] <= i_mem_rdata;
        end
    end

    assign o_rdata_line = w_rdata;
    assign o_valid_out  = r_valid_out;
    assign o_stall_cpu  = i_req && !w_hit;
    assign o_flush_busy = (r_state == StFlush);
    assign o_mem_req    = (r_state == StRefill);
    assign o_mem_we     = 1'b0;
    assign o_mem_addr   = (r_state == StRefill) ? r_line_addr : 32'h0;

endmodule

// File: tb/tb_icache_nway.sv
// Self-checking bench for icache_nway (4 ways, 64 sets, 128-bit lines): directed
// sequences, a fill-order table and randomized fetches against a line-level model.
module tb_icache_nway;

    localparam int unsigned WAYS      = 4;
    localparam int unsigned SET_BITS  = 6;
    localparam int unsigned LINE_BITS = 128;
    localparam int unsigned SETS      = 64;

    logic                 clk;
    logic                 rst_n;
    logic [31:0]          i_paddr;
    logic                 i_req;
    logic [LINE_BITS-1:0] o_rdata_line;
    logic                 o_valid_out;
    logic                 o_stall_cpu;
    logic                 i_flush_req;
    logic                 o_flush_busy;
    logic                 o_mem_req;
    logic                 o_mem_we;
    logic [31:0]          o_mem_addr;
    logic [LINE_BITS-1:0] i_mem_rdata;
    logic                 i_mem_ready;
    logic [31:0]          i_mem_resp_addr;

    icache_nway #(
        .WAYS      (WAYS),
        .SET_BITS  (SET_BITS),
        .LINE_BITS (LINE_BITS)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_paddr         (i_paddr),
        .i_req           (i_req),
        .o_rdata_line    (o_rdata_line),
        .o_valid_out     (o_valid_out),
        .o_stall_cpu     (o_stall_cpu),
        .i_flush_req     (i_flush_req),
        .o_flush_busy    (o_flush_busy),
        .o_mem_req       (o_mem_req),
        .o_mem_we        (o_mem_we),
        .o_mem_addr      (o_mem_addr),
        .i_mem_rdata     (i_mem_rdata),
        .i_mem_ready     (i_mem_ready),
        .i_mem_resp_addr (i_mem_resp_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Line-level reference: which line address sits in which way, plus the pointer.
    bit              m_valid [SETS][WAYS];
    logic [31:0]     m_addr  [SETS][WAYS];
    logic [127:0]    m_data  [SETS][WAYS];
    int              m_ptr   [SETS];

    function automatic int m_set(input logic [31:0] la);
        return int'((la >> 4) & 32'h3F);
    endfunction

    function automatic int m_lookup(input logic [31:0] la);
        int s;
        s = m_set(la);
        for (int w = 0; w < WAYS; w++) begin
            if (m_valid[s][w] && m_addr[s][w] == la) return w;
        end
        return -1;
    endfunction

    task automatic m_fill(input logic [31:0] la, input logic [127:0] d);
        int s;
        int v;
        s = m_set(la);
        v = -1;
        for (int w = 0; w < WAYS; w++) begin
            if (!m_valid[s][w] && v < 0) v = w;
        end
        if (v < 0) v = m_ptr[s];
        m_valid[s][v] = 1'b1;
        m_addr[s][v]  = la;
        m_data[s][v]  = d;
        if (v == m_ptr[s]) m_ptr[s] = (m_ptr[s] + 1) % WAYS;
    endtask

    task automatic m_clear();
        for (int s = 0; s < SETS; s++) begin
            m_ptr[s] = 0;
            for (int w = 0; w < WAYS; w++) m_valid[s][w] = 1'b0;
        end
    endtask

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] rand_line();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // One fetch: hit path, or miss -> refill (optional stale response, delay d) -> hit.
    task automatic fetch(input logic [31:0] a, input bit exp_hit, input logic [127:0] line,
                         input bit stale, input int d);
        logic [31:0]  la;
        logic [127:0] want;
        int           w;
        la = a & ~32'hF;
        i_req   = 1'b1;
        i_paddr = a;
        #1;
        check("stall_lookup", o_stall_cpu, exp_hit ? 1'b0 : 1'b1);
        if (exp_hit) begin
            w    = m_lookup(la);
            want = (w >= 0) ? m_data[m_set(la)][w] : '0;
            check("hit_data", o_rdata_line, want);
            tick();
            check("hit_valid_out", o_valid_out, 1'b1);
        end else begin
            tick();
            check("miss_mem_req", o_mem_req, 1'b1);
            check("miss_mem_addr", o_mem_addr, la);
            check("miss_mem_we", o_mem_we, 1'b0);
            i_paddr = ~a;
            for (int i = 0; i < d; i++) tick();
            if (stale) begin
                i_mem_ready     = 1'b1;
                i_mem_resp_addr = la ^ 32'h0000_1000;
                i_mem_rdata     = ~line;
                tick();
                i_mem_ready = 1'b0;
                #1;
                check("stale_mem_req", o_mem_req, 1'b1);
                check("stale_stall", o_stall_cpu, 1'b1);
            end
            i_mem_ready     = 1'b1;
            i_mem_resp_addr = la;
            i_mem_rdata     = line;
            tick();
            i_mem_ready = 1'b0;
            i_paddr     = a;
            #1;
            m_fill(la, line);
            check("fill_mem_req_low", o_mem_req, 1'b0);
            check("fill_mem_addr_low", o_mem_addr, 32'h0);
            check("fill_hit_stall", o_stall_cpu, 1'b0);
            check("fill_hit_data", o_rdata_line, line);
            tick();
            check("fill_valid_out", o_valid_out, 1'b1);
        end
        i_req = 1'b0;
        tick();
        check("valid_out_pulse", o_valid_out, 1'b0);
    endtask

    // Counts FLUSH cycles from the current cycle while holding a request.
    task automatic count_flush(output int n, output int bad);
        n   = 0;
        bad = 0;
        i_req   = 1'b1;
        i_paddr = 32'h0000_1000;
        for (int i = 0; i < 300; i++) begin
            #1;
            if (!o_flush_busy) break;
            n++;
            if (!o_stall_cpu || o_mem_req || o_valid_out || o_mem_addr != 32'h0) bad++;
            tick();
        end
        i_req = 1'b0;
        m_clear();
    endtask

    task automatic flush_seq();
        int n;
        int bad;
        i_flush_req = 1'b1;
        tick();
        i_flush_req = 1'b0;
        count_flush(n, bad);
        check("flush_len", n, SETS);
        check("flush_stall", bad, 0);
    endtask

    typedef struct {
        logic [31:0] addr;
        bit          exp_hit;
    } vec_t;

    vec_t         tbl [18];
    logic [31:0]  a;
    logic [127:0] ln;
    int           n;
    int           bad;
    int           waited;

    initial begin
        tbl[0]  = '{32'h0000, 1'b0};  tbl[1]  = '{32'h0400, 1'b0};
        tbl[2]  = '{32'h0800, 1'b0};  tbl[3]  = '{32'h0C00, 1'b0};
        tbl[4]  = '{32'h0000, 1'b1};  tbl[5]  = '{32'h0404, 1'b1};
        tbl[6]  = '{32'h0808, 1'b1};  tbl[7]  = '{32'h0C0C, 1'b1};
        tbl[8]  = '{32'h1000, 1'b0};  tbl[9]  = '{32'h0000, 1'b0};
        tbl[10] = '{32'h0400, 1'b0};  tbl[11] = '{32'h0C00, 1'b1};
        tbl[12] = '{32'h1000, 1'b1};  tbl[13] = '{32'h0000, 1'b1};
        tbl[14] = '{32'h0800, 1'b0};  tbl[15] = '{32'h0C00, 1'b0};
        tbl[16] = '{32'h0400, 1'b1};  tbl[17] = '{32'h1000, 1'b0};

        m_clear();
        rst_n           = 1'b0;
        i_paddr         = '0;
        i_req           = 1'b0;
        i_flush_req     = 1'b0;
        i_mem_rdata     = '0;
        i_mem_ready     = 1'b0;
        i_mem_resp_addr = '0;
        tick();
        tick();
        check("rst_valid_out", o_valid_out, 1'b0);
        check("rst_mem_req", o_mem_req, 1'b0);
        check("rst_mem_we", o_mem_we, 1'b0);
        check("rst_mem_addr", o_mem_addr, 32'h0);
        check("rst_flush_busy", o_flush_busy, 1'b0);
        check("rst_stall_idle", o_stall_cpu, 1'b0);
        rst_n = 1'b1;
        tick();

        // Cold miss, then stale response during a refill.
        fetch(32'h0000_1000, 1'b0, 128'h1111_2222_3333_4444_5555_6666_7777_8888, 1'b0, 0);
        fetch(32'h0000_1004, 1'b1, '0, 1'b0, 0);
        fetch(32'h0000_2000, 1'b0, 128'hDEAD_BEEF_0000_2000_CAFE_F00D_1234_5678, 1'b1, 1);

        // Flush with lines resident; both must miss afterwards.
        flush_seq();
        fetch(32'h0000_1000, 1'b0, rand_line(), 1'b0, 0);
        fetch(32'h0000_2000, 1'b0, rand_line(), 1'b0, 2);
        flush_seq();

        // Fill order / round-robin on set 0.
        for (int i = 0; i < 18; i++) begin
            a = tbl[i].addr;
            fetch(a, tbl[i].exp_hit, {4{a ^ 32'hA5A5_0000}}, 1'b0, 0);
        end

        // Flush arriving on refill cycle 2.
        ln      = rand_line();
        i_req   = 1'b1;
        i_paddr = 32'h0000_5000;
        tick();
        check("fdr_mem_req", o_mem_req, 1'b1);
        tick();
        i_flush_req = 1'b1;
        tick();
        i_flush_req = 1'b0;
        check("fdr_hold", o_mem_req, 1'b1);
        i_mem_ready     = 1'b1;
        i_mem_resp_addr = 32'h0000_5000;
        i_mem_rdata     = ln;
        tick();
        i_mem_ready = 1'b0;
        #1;
        check("fdr_pending_stall", o_stall_cpu, 1'b1);
        i_req  = 1'b0;
        waited = 0;
        while (!o_flush_busy && waited < 5) begin
            tick();
            waited++;
        end
        check("fdr_flush_start", o_flush_busy, 1'b1);
        count_flush(n, bad);
        check("fdr_flush_len", n, SETS);
        check("fdr_flush_stall", bad, 0);
        fetch(32'h0000_5000, 1'b0, rand_line(), 1'b0, 0);

        // Reset while a refill is outstanding; a late response must be ignored.
        fetch(32'h0000_0040, m_lookup(32'h40) >= 0, rand_line(), 1'b0, 0);
        i_req   = 1'b1;
        i_paddr = 32'h0000_6000;
        tick();
        check("rmr_mem_req", o_mem_req, 1'b1);
        rst_n = 1'b0;
        #1;
        check("rmr_mem_req_low", o_mem_req, 1'b0);
        check("rmr_mem_addr_low", o_mem_addr, 32'h0);
        check("rmr_valid_out_low", o_valid_out, 1'b0);
        check("rmr_flush_busy_low", o_flush_busy, 1'b0);
        tick();
        rst_n = 1'b1;
        i_req = 1'b0;
        m_clear();
        i_mem_ready     = 1'b1;
        i_mem_resp_addr = 32'h0000_6000;
        tick();
        i_mem_ready = 1'b0;
        #1;
        check("late_ready_ignored", o_mem_req, 1'b0);
        fetch(32'h0000_0040, 1'b0, rand_line(), 1'b0, 0);
        fetch(32'h0000_6000, 1'b0, rand_line(), 1'b0, 0);

        // Randomized fetches over 8 tags x 4 sets to force evictions.
        for (int k = 0; k < 200; k++) begin
            if ($urandom_range(0, 99) < 4) begin
                flush_seq();
            end else begin
                a = (32'($urandom_range(0, 7)) << 10) | (32'($urandom_range(0, 3)) << 4)
                    | 32'($urandom_range(0, 15));
                fetch(a, m_lookup(a & ~32'hF) >= 0, rand_line(), $urandom_range(0, 3) == 0,
                      int'($urandom_range(0, 2)));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL timeout: got no finish, want finish");
        $fatal(1, "timeout");
    end

endmodule
